spi_bus_arbiter: RTL and testbench
==================================

# spi_bus_arbiter

- Shares one SPI byte engine (the SPIinterface byte shifter: `send_data` / `begin_transmission` / `end_transmission` / `received_data`) between N sensor controllers, e.g. the ACL2 accelerometer sequencer and a gyro sequencer.
- Arbitrates whole transactions round-robin and drives a per-slave active-low chip select.
- Forwards bytes one at a time, returns each received byte to the owning requester, and enforces an inter-transaction chip-select gap and a per-byte watchdog.

## Interface

Parameters:

- `N_REQ`, 2 — number of requesters and slave chip selects (2..4).
- `GAP_CYCLES`, 3 — `clk` cycles all `cs_n` stay high between transactions (≥1).
- `TIMEOUT`, 4095 — max `clk` cycles waiting for `end_transmission` per byte (12-bit counter).

Ports:

- `clk`  in  1  — system clock; one clock domain.
- `rst`  in  1  — asynchronous, active-low reset.
- `req`  in  N_REQ  — requester holds high for the entire multi-byte transaction.
- `req_byte_valid`  in  N_REQ  — one-cycle strobe: byte on `req_data` slice is ready.
- `req_data`  in  8*N_REQ  — byte per requester, slice i = bits [8i+7:8i].
- `gnt`  out  N_REQ  — one-hot owner of the bus.
- `byte_done`  out  N_REQ  — one-cycle pulse to owner: byte finished, `rx_data` valid.
- `rx_data`  out  8  — last received byte; holds until the next byte completes.
- `timeout_err`  out  N_REQ  — one-cycle pulse: owner's byte aborted by the watchdog.
- `cs_n`  out  N_REQ  — per-slave chip select, active low; at most one low.
- `send_data`  out  8  — byte to the SPI engine.
- `begin_transmission`  out  1  — level, high from byte launch until `end_transmission`.
- `end_transmission`  in  1  — one-cycle pulse from the SPI engine at byte end.
- `received_data`  in  8  — engine's received byte, valid with `end_transmission`.
- `busy`  out  1  — high in any state other than IDLE.

## Operation

States are IDLE, SETUP, ACTIVE, XFER and GAP.

- **IDLE**
  - If any `req` is high, select the first requester at or after round-robin pointer `ptr` (wrapping).
  - Register `gnt`, drive that `cs_n` low, set `ptr` = sel+1 mod N_REQ, go to SETUP.
- **SETUP**
  - One cycle of chip-select setup, then go to ACTIVE.
- **ACTIVE**
  - If `req[sel]` is low, go to GAP; any coincident `req_byte_valid[sel]` is dropped.
  - Else on `req_byte_valid[sel]`: latch the `req_data` slice into `send_data`, set `begin_transmission`, clear the watchdog, go to XFER.
- **XFER**
  - On `end_transmission`: clear `begin_transmission`, load `rx_data` from `received_data`, pulse `byte_done[sel]`, go to ACTIVE.
  - Watchdog reaching TIMEOUT before `end_transmission`: clear `begin_transmission`, pulse `timeout_err[sel]`, go to GAP.
  - `req[sel]` falling during XFER does not abort the byte; the next ACTIVE cycle exits to GAP.
- **GAP**
  - All `cs_n` high, `gnt` all zero.
  - Count GAP_CYCLES, then go to IDLE.
- **Ignored inputs**
  - `req_byte_valid` from non-owners is ignored.
  - `req_byte_valid` from the owner outside ACTIVE is ignored; requesters wait for `gnt` or `byte_done` before strobing.
  - `end_transmission` outside XFER is ignored.

## Timing

- **Reset values:** all outputs are 0, except `cs_n` = all ones; `ptr` = 0; state = IDLE.
- **Reset mid-transfer:** takes effect asynchronously; `cs_n` deasserts immediately.
- **Grant latency:**
  - `req` high at IDLE edge t gives `gnt` and `cs_n` low valid after edge t.
  - State is SETUP in cycle t+1; first `req_byte_valid` is accepted at edge t+2.
- **Byte launch:** a strobe accepted at edge a makes `send_data` and `begin_transmission` valid after edge a.
- **Byte completion:**
  - `end_transmission` sampled at edge e gives `begin_transmission` low, `rx_data` valid and `byte_done` high for exactly one cycle after edge e.
  - A new strobe is accepted at edge e+1 earliest.
- **Watchdog:**
  - Counts `clk` cycles in XFER starting at 1.
  - Abort at count == TIMEOUT, i.e. TIMEOUT cycles after launch.
  - `end_transmission` on the same edge as the abort wins (normal completion).
- **End of transaction:**
  - `cs_n` goes high on the edge leaving ACTIVE.
  - The next grant appears GAP_CYCLES+1 edges later.
- **Fairness:** with all `req` held continuously, grants rotate 0,1,…,N_REQ-1,0.
- **Simultaneous requests:** resolved only in IDLE; a `req` rising during another transaction waits.

## Test plan

- **Single requester:** N_REQ=2, `req[0]` sends 8'h0B then 8'h08 with engine returning 8'h00, 8'hF2, then drops `req` → `cs_n` = 2'b10 throughout; two `byte_done[0]` pulses with `rx_data` = 8'hF2 on the second; `cs_n` = 2'b11 after; 3-cycle gap.
- **Simultaneous requests:** `req` = 2'b11 from reset → `gnt[0]` first; after its release, `gnt[1]` exactly GAP_CYCLES+1 cycles after `cs_n[0]` rises; third grant goes to 0.
- **Watchdog:** engine never pulses `end_transmission`, TIMEOUT=16 → `timeout_err[0]` pulses 16 cycles after launch; `begin_transmission` low; `cs_n` high; no `byte_done`.
- **Ignored strobes:** non-owner `req_byte_valid[1]` with data 8'hAA during owner 0's XFER → `send_data` unchanged; no `byte_done[1]`.
- **Drop in flight:** `req[0]` falls mid-XFER → byte completes with `byte_done[0]`, then GAP on the next cycle.
- **Reset mid-byte:** `rst` low during XFER → `cs_n` = all ones, `begin_transmission` = 0, `gnt` = 0 immediately; after release the first grant honours `ptr` = 0.

Source files
------------

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI byte engine between N_REQ requesters,
// with per-slave active-low chip selects, an inter-transaction gap and a
// per-byte watchdog.
module spi_bus_arbiter #(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned GAP_CYCLES = 3,
    parameter int unsigned TIMEOUT    = 4095
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     req_byte_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     byte_done,
    output logic [7:0]           rx_data,
    output logic [N_REQ-1:0]     timeout_err,
    output logic [N_REQ-1:0]     cs_n,
    output logic [7:0]           send_data,
    output logic                 begin_transmission,
    input  logic                 end_transmission,
    input  logic [7:0]           received_data,
    output logic                 busy
);

    localparam int unsigned SW = $clog2(N_REQ);
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned WW = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACTIVE,
        ST_XFER,
        ST_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    sel_q, sel_d;
    logic [SW-1:0]    ptr_q, ptr_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [WW-1:0]    wd_q, wd_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] cs_n_q, cs_n_d;
    logic [N_REQ-1:0] byte_done_q, byte_done_d;
    logic [N_REQ-1:0] timeout_q, timeout_d;
    logic [7:0]       rx_q, rx_d;
    logic [7:0]       send_q, send_d;
    logic             begin_q, begin_d;
    logic             busy_q, busy_d;

    logic             rr_hit;
    logic [SW-1:0]    rr_sel;

    // Round-robin pick: first active request at or after ptr, wrapping.
    always_comb begin
        rr_hit = 1'b0;
        rr_sel = ptr_q;
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            if (req[SW'((int'(ptr_q) + k) % int'(N_REQ))]) begin
                rr_hit = 1'b1;
                rr_sel = SW'((int'(ptr_q) + k) % int'(N_REQ));
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        gap_d       = gap_q;
        wd_d        = wd_q;
        gnt_d       = gnt_q;
        cs_n_d      = cs_n_q;
        rx_d        = rx_q;
        send_d      = send_q;
        begin_d     = begin_q;
        byte_done_d = '0;
        timeout_d   = '0;

        case (state_q)
            ST_IDLE: begin
                if (rr_hit) begin
                    sel_d   = rr_sel;
                    gnt_d   = N_REQ'(1) << rr_sel;
                    cs_n_d  = ~(N_REQ'(1) << rr_sel);
                    ptr_d   = (rr_sel == SW'(N_REQ - 1)) ? '0 : rr_sel + SW'(1);
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (!req[sel_q]) begin
                    gnt_d   = '0;
                    cs_n_d  = '1;
                    gap_d   = '0;
                    state_d = ST_GAP;
                end else if (req_byte_valid[sel_q]) begin
                    send_d  = req_data[{sel_q, 3'b000} +: 8];
                    begin_d = 1'b1;
                    wd_d    = WW'(1);
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (end_transmission) begin
                    begin_d     = 1'b0;
                    rx_d        = received_data;
                    byte_done_d = N_REQ'(1) << sel_q;
                    state_d     = ST_ACTIVE;
                end else if (wd_q == WW'(TIMEOUT)) begin
                    begin_d   = 1'b0;
                    timeout_d = N_REQ'(1) << sel_q;
                    gnt_d     = '0;
                    cs_n_d    = '1;
                    gap_d     = '0;
                    state_d   = ST_GAP;
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                gnt_d   = '0;
                cs_n_d  = '1;
                begin_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset forces chip selects high at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            ptr_q       <= '0;
            gap_q       <= '0;
            wd_q        <= '0;
            gnt_q       <= '0;
            cs_n_q      <= '1;
            byte_done_q <= '0;
            timeout_q   <= '0;
            rx_q        <= '0;
            send_q      <= '0;
            begin_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            gap_q       <= gap_d;
            wd_q        <= wd_d;
            gnt_q       <= gnt_d;
            cs_n_q      <= cs_n_d;
            byte_done_q <= byte_done_d;
            timeout_q   <= timeout_d;
            rx_q        <= rx_d;
            send_q      <= send_d;
            begin_q     <= begin_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt                = gnt_q;
    assign cs_n               = cs_n_q;
    assign byte_done          = byte_done_q;
    assign timeout_err        = timeout_q;
    assign rx_data            = rx_q;
    assign send_data          = send_q;
    assign begin_transmission = begin_q;
    assign busy               = busy_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter (N_REQ=2, GAP_CYCLES=3, TIMEOUT=16).
module tb_spi_bus_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  req_byte_valid;
    logic [15:0] req_data;
    logic [1:0]  gnt;
    logic [1:0]  byte_done;
    logic [7:0]  rx_data;
    logic [1:0]  timeout_err;
    logic [1:0]  cs_n;
    logic [7:0]  send_data;
    logic        begin_transmission;
    logic        end_transmission;
    logic [7:0]  received_data;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;

    spi_bus_arbiter #(
        .N_REQ      (2),
        .GAP_CYCLES (3),
        .TIMEOUT    (16)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .req                (req),
        .req_byte_valid     (req_byte_valid),
        .req_data           (req_data),
        .gnt                (gnt),
        .byte_done          (byte_done),
        .rx_data            (rx_data),
        .timeout_err        (timeout_err),
        .cs_n               (cs_n),
        .send_data          (send_data),
        .begin_transmission (begin_transmission),
        .end_transmission   (end_transmission),
        .received_data      (received_data),
        .busy               (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  rbv;
        logic [15:0] data;
        logic        et;
        logic [7:0]  rxi;
        logic [1:0]  gnt;
        logic [1:0]  cs_n;
        logic        bt;
        logic [1:0]  bd;
        logic [7:0]  rx;
        logic [7:0]  sd;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [1:0] r, logic [1:0] v, logic [15:0] d, logic e,
                                logic [7:0] ri, logic [1:0] g, logic [1:0] c, logic b,
                                logic [1:0] bd, logic [7:0] rx, logic [7:0] sd, logic bs);
        vec_t t;
        t.req = r; t.rbv = v; t.data = d; t.et = e; t.rxi = ri;
        t.gnt = g; t.cs_n = c; t.bt = b; t.bd = bd; t.rx = rx; t.sd = sd; t.busy = bs;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input logic [1:0] exp, output int n);
        n = 0;
        while (gnt !== exp && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    int n;

    initial begin
        rst              = 1'b0;
        req              = '0;
        req_byte_valid   = '0;
        req_data         = '0;
        end_transmission = 1'b0;
        received_data    = '0;

        // Single transaction, ignored strobes, drop in flight, stray end_transmission.
        vecs.push_back(mk(2'b01, 2'b00, 16'h0000, 1'b0, 8'h00, 2'b01, 2'b10, 1'b0, 2'b00, 8'h00, 8'h00, 1'b1));
        vecs.push_back(mk(2'b01, 2'b00, 16'h0000, 1'b0, 8'h00, 2'b01, 2'b10, 1'b0, 2'b00, 8'h00, 8'h00, 1'b1));
        vecs.push_back(mk(2'b01, 2'b01, 16'h000B, 1'b0, 8'h00, 2'b01, 2'b10, 1'b1, 2'b00, 8'h00, 8'h0B, 1'b1));
        vecs.push_back(mk(2'b01, 2'b00, 16'h000B, 1'b0, 8'h00, 2'b01, 2'b10, 1'b1, 2'b00, 8'h00, 8'h0B, 1'b1));
        vecs.push_back(mk(2'b01, 2'b00, 16'h000B, 1'b1, 8'h00, 2'b01, 2'b10, 1'b0, 2'b01, 8'h00, 8'h0B, 1'b1));
        vecs.push_back(mk(2'b01, 2'b01, 16'h0008, 1'b0, 8'h00, 2'b01, 2'b10, 1'b1, 2'b00, 8'h00, 8'h08, 1'b1));
        vecs.push_back(mk(2'b01, 2'b00, 16'h0008, 1'b1, 8'hF2, 2'b01, 2'b10, 1'b0, 2'b01, 8'hF2, 8'h08, 1'b1));
        vecs.push_back(mk(2'b00, 2'b00, 16'h0000, 1'b0, 8'h00, 2'b00, 2'b11, 1'b0, 2'b00, 8'hF2, 8'h08, 1'b1));
        vecs.push_back(mk(2'b00, 2'b00, 16'h0000, 1'b0, 8'h00, 2'b00, 2'b11, 1'b0, 2'b00, 8'hF2, 8'h08, 1'b1));
        vecs.push_back(mk(2'b00, 2'b00, 16'h0000, 1'b0, 8'h00, 2'b00, 2'b11, 1'b0, 2'b00, 8'hF2, 8'h08, 1'b1));
        vecs.push_back(mk(2'b00, 2'b00, 16'h0000, 1'b0, 8'h00, 2'b00, 2'b11, 1'b0, 2'b00, 8'hF2, 8'h08, 1'b0));
        vecs.push_back(mk(2'b00, 2'b00, 16'h0000, 1'b0, 8'h00, 2'b00, 2'b11, 1'b0, 2'b00, 8'hF2, 8'h08, 1'b0));
        vecs.push_back(mk(2'b01, 2'b00, 16'h0000, 1'b0, 8'h00, 2'b01, 2'b10, 1'b0, 2'b00, 8'hF2, 8'h08, 1'b1));
        vecs.push_back(mk(2'b01, 2'b00, 16'h0000, 1'b0, 8'h00, 2'b01, 2'b10, 1'b0, 2'b00, 8'hF2, 8'h08, 1'b1));
        vecs.push_back(mk(2'b01, 2'b01, 16'h0055, 1'b0, 8'h00, 2'b01, 2'b10, 1'b1, 2'b00, 8'hF2, 8'h55, 1'b1));
        vecs.push_back(mk(2'b01, 2'b10, 16'hAA55, 1'b0, 8'h00, 2'b01, 2'b10, 1'b1, 2'b00, 8'hF2, 8'h55, 1'b1));
        vecs.push_back(mk(2'b00, 2'b00, 16'hAA55, 1'b0, 8'h00, 2'b01, 2'b10, 1'b1, 2'b00, 8'hF2, 8'h55, 1'b1));
        vecs.push_back(mk(2'b00, 2'b00, 16'h0000, 1'b1, 8'h3C, 2'b01, 2'b10, 1'b0, 2'b01, 8'h3C, 8'h55, 1'b1));
        vecs.push_back(mk(2'b00, 2'b00, 16'h0000, 1'b0, 8'h00, 2'b00, 2'b11, 1'b0, 2'b00, 8'h3C, 8'h55, 1'b1));
        vecs.push_back(mk(2'b00, 2'b00, 16'h0000, 1'b1, 8'h77, 2'b00, 2'b11, 1'b0, 2'b00, 8'h3C, 8'h55, 1'b1));
        vecs.push_back(mk(2'b00, 2'b00, 16'h0000, 1'b0, 8'h00, 2'b00, 2'b11, 1'b0, 2'b00, 8'h3C, 8'h55, 1'b1));
        vecs.push_back(mk(2'b00, 2'b00, 16'h0000, 1'b0, 8'h00, 2'b00, 2'b11, 1'b0, 2'b00, 8'h3C, 8'h55, 1'b0));

        // Reset values.
        step();
        step();
        chk("rst_gnt",  32'(gnt), 32'h0);
        chk("rst_cs_n", 32'(cs_n), 32'h3);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_bt",   32'(begin_transmission), 32'h0);
        chk("rst_send", 32'(send_data), 32'h0);
        chk("rst_rx",   32'(rx_data), 32'h0);
        chk("rst_bd",   32'(byte_done), 32'h0);
        chk("rst_to",   32'(timeout_err), 32'h0);
        rst = 1'b1;
        step();

        foreach (vecs[i]) begin
            req              = vecs[i].req;
            req_byte_valid   = vecs[i].rbv;
            req_data         = vecs[i].data;
            end_transmission = vecs[i].et;
            received_data    = vecs[i].rxi;
            step();
            chk($sformatf("v%0d_gnt", i),  32'(gnt), 32'(vecs[i].gnt));
            chk($sformatf("v%0d_cs_n", i), 32'(cs_n), 32'(vecs[i].cs_n));
            chk($sformatf("v%0d_bt", i),   32'(begin_transmission), 32'(vecs[i].bt));
            chk($sformatf("v%0d_bd", i),   32'(byte_done), 32'(vecs[i].bd));
            chk($sformatf("v%0d_rx", i),   32'(rx_data), 32'(vecs[i].rx));
            chk($sformatf("v%0d_send", i), 32'(send_data), 32'(vecs[i].sd));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            chk($sformatf("v%0d_to", i),   32'(timeout_err), 32'h0);
        end
        req_byte_valid   = '0;
        end_transmission = 1'b0;

        // Simultaneous requests from reset.
        do_reset();
        req = 2'b11;
        step();
        chk("sim_first_gnt", 32'(gnt), 32'h1);
        step();
        req = 2'b10;
        step();
        chk("sim_release_cs", 32'(cs_n), 32'h3);
        wait_gnt(2'b10, n);
        chk("sim_second_gnt_lat", 32'(n), 32'd4);
        chk("sim_second_cs", 32'(cs_n), 32'h1);
        req = 2'b01;
        step();
        step();
        chk("sim_release1_cs", 32'(cs_n), 32'h3);
        wait_gnt(2'b01, n);
        chk("sim_third_gnt_lat", 32'(n), 32'd4);

        // Watchdog abort after 16 cycles.
        step();
        req_byte_valid = 2'b01;
        req_data       = 16'h00A5;
        step();
        req_byte_valid = '0;
        chk("wd_launch_bt", 32'(begin_transmission), 32'h1);
        chk("wd_launch_send", 32'(send_data), 32'hA5);
        repeat (15) step();
        chk("wd_pre_to", 32'(timeout_err), 32'h0);
        chk("wd_pre_bt", 32'(begin_transmission), 32'h1);
        step();
        chk("wd_to", 32'(timeout_err), 32'h1);
        chk("wd_bt", 32'(begin_transmission), 32'h0);
        chk("wd_cs", 32'(cs_n), 32'h3);
        chk("wd_gnt", 32'(gnt), 32'h0);
        chk("wd_bd", 32'(byte_done), 32'h0);
        step();
        chk("wd_to_pulse", 32'(timeout_err), 32'h0);

        // end_transmission on the abort edge completes normally.
        wait_gnt(2'b01, n);
        chk("wd_regrant", 32'(n < 20), 32'h1);
        step();
        req_byte_valid = 2'b01;
        req_data       = 16'h005A;
        step();
        req_byte_valid = '0;
        repeat (15) step();
        end_transmission = 1'b1;
        received_data    = 8'hC3;
        step();
        end_transmission = 1'b0;
        chk("race_bd", 32'(byte_done), 32'h1);
        chk("race_to", 32'(timeout_err), 32'h0);
        chk("race_rx", 32'(rx_data), 32'hC3);
        chk("race_cs", 32'(cs_n), 32'h2);

        // Asynchronous reset mid-byte, then grant restarts from ptr 0.
        req_byte_valid = 2'b01;
        req_data       = 16'h0066;
        step();
        req_byte_valid = '0;
        step();
        #2 rst = 1'b0;
        #1;
        chk("arst_cs", 32'(cs_n), 32'h3);
        chk("arst_bt", 32'(begin_transmission), 32'h0);
        chk("arst_gnt", 32'(gnt), 32'h0);
        req = 2'b11;
        #2 rst = 1'b1;
        step();
        chk("arst_ptr_gnt", 32'(gnt), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
